// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result buffer.
// Imported by the buffer top and its flag helper.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_flags.sv
// Zero/negative flag generation for an ALU result word.
// Purely combinational; sits on the buffer capture path.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             neg
);

  assign zero = (data == '0);
  assign neg  = data[WIDTH-1];

endmodule

// File: rtl/alu_out_buf.sv
// Two-entry in-order skid buffer between the ALU and writeback.
// Flags travel with each entry so outputs are pure register reads.
module alu_out_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg,
  output logic [1:0]       count
);

  buf_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_zero_q, head_zero_d;
  logic             head_neg_q, head_neg_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic             tail_zero_q, tail_zero_d;
  logic             tail_neg_q, tail_neg_d;
  logic             cap_zero, cap_neg;
  logic             push, pop;

  alu_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .data(in_data),
    .zero(cap_zero),
    .neg (cap_neg)
  );

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_zero_d = head_zero_q;
    head_neg_d  = head_neg_q;
    tail_data_d = tail_data_q;
    tail_zero_d = tail_zero_q;
    tail_neg_d  = tail_neg_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_data_d = in_data;
          head_zero_d = cap_zero;
          head_neg_d  = cap_neg;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_data_d = in_data;
          head_zero_d = cap_zero;
          head_neg_d  = cap_neg;
        end else if (push) begin
          tail_data_d = in_data;
          tail_zero_d = cap_zero;
          tail_neg_d  = cap_neg;
          state_d     = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_zero_d = tail_zero_q;
          head_neg_d  = tail_neg_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is registered off the next state to keep out_ready off the path.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_zero_q <= 1'b0;
      head_neg_q  <= 1'b0;
      tail_data_q <= '0;
      tail_zero_q <= 1'b0;
      tail_neg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_zero_q <= head_zero_d;
      head_neg_q  <= head_neg_d;
      tail_data_q <= tail_data_d;
      tail_zero_q <= tail_zero_d;
      tail_neg_q  <= tail_neg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data_q;
  assign out_zero  = head_zero_q;
  assign out_neg   = head_neg_q;
  assign count     = state_q;

endmodule

// File: doc/alu_out_buf.md
ALU_OUT_BUF -- requirements
Module: alu_out_buf

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the result data width in bits.
REQ-002 The module SHALL have input port clock, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have input port reset, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have input port in_valid, 1 bit, meaning the upstream ALU result is present.
REQ-005 The module SHALL have output port in_ready, 1 bit, meaning the buffer can accept a result this cycle.
REQ-006 The module SHALL have input port in_data, WIDTH bits, the ALU result word (bitwise logic-unit output or adder output).
REQ-007 The module SHALL have output port out_valid, 1 bit, meaning the head entry is present.
REQ-008 The module SHALL have input port out_ready, 1 bit, meaning the downstream (writeback) consumes the head this cycle.
REQ-009 The module SHALL have output port out_data, WIDTH bits, the head result word.
REQ-010 The module SHALL have output port out_zero, 1 bit, set when the head result equals 0.
REQ-011 The module SHALL have output port out_neg, 1 bit, equal to the head result bit WIDTH-1.
REQ-012 The module SHALL have output port count, 2 bits, giving the occupancy (0..2).

Function
REQ-013 The module SHALL implement a 2-entry in-order buffer with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-014 A push SHALL occur when in_valid && in_ready, and a pop when out_valid && out_ready.
REQ-015 in_ready SHALL be driven from a register, equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready.
REQ-016 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-017 Transitions SHALL be: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with head = new word; FULL+pop->ONE with head = former tail; all other combinations hold state.
REQ-018 Latency SHALL be one cycle: a word pushed at edge N appears on out_data with out_valid=1 after edge N when the buffer was EMPTY.
REQ-019 out_zero and out_neg SHALL be computed at capture time and stored with each entry, so they are never a combinational function of out_data.
REQ-020 Order SHALL be strict FIFO, with no word dropped or duplicated under any in_valid/out_ready pattern.
REQ-021 A push attempted in FULL SHALL be ignored, since in_ready=0 in that state.
REQ-022 A pop attempted in EMPTY SHALL be ignored and SHALL leave state unchanged.
REQ-023 When out_valid=0, out_data, out_zero and out_neg SHALL hold their last value.

Reset
REQ-024 While reset=1 at a rising clock edge, state SHALL become EMPTY, count=0, in_ready=1, out_valid=0, out_data=0, out_zero=0 and out_neg=0, regardless of in_valid and out_ready.
REQ-025 Reset asserted mid-transfer SHALL discard both entries, and a push presented in the same cycle SHALL NOT be captured.
REQ-026 The first push SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-027 The state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the default WIDTH constant SHALL reside in the shared package alu_pkg.
REQ-028 The zero/negative flag computation SHALL be a separate combinational sub-module alu_flags (inputs: data; outputs: zero, neg), instantiated once on the capture path.
REQ-029 Storage SHALL be two head/tail entry registers plus the state register, with no memory inference.

Verification
REQ-030 The bench SHALL cover: reset, then push 32'h0000_0000 with out_ready=1 -> next cycle out_valid=1, out_data=0, out_zero=1, out_neg=0, count=1.
REQ-031 The bench SHALL cover: push 32'h8000_0001 then 32'h0000_0005 with out_ready=0 -> count=2, in_ready=0; third push 32'hFFFF_FFFF ignored; then out_ready=1 -> outputs 8000_0001 (out_neg=1) then 0000_0005.
REQ-032 The bench SHALL cover: in ONE, simultaneous push 32'h1234_5678 and pop -> count stays 1, out_data=1234_5678 next cycle.
REQ-033 The bench SHALL cover: in FULL, assert reset for one cycle with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_data=0; the word is not captured.
REQ-034 The bench SHALL cover: 1000 random in_valid/out_ready cycles with random data -> output sequence equals input sequence, count never exceeds 2, and no pop occurs while out_valid=0.
